// File: rtl/circuit1_pkg.sv
// rtl/circuit1_pkg.sv - shared width default and FSM encodings for circuit1_sched
package circuit1_pkg;

    localparam int DATAWIDTH_DEF = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S_D  = 3'd1;
    localparam logic [2:0] ST_S_E  = 3'd2;
    localparam logic [2:0] ST_S_CM = 3'd3;
    localparam logic [2:0] ST_S_X  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/circuit1_addsub.sv
// rtl/circuit1_addsub.sv - single shared adder/subtractor, subtract via inverted B plus carry-in
module circuit1_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sub,
    output logic [W-1:0] result
);

    logic [W-1:0] b_eff;

    assign b_eff  = B ^ {W{sub}};
    assign result = A + b_eff + W'(sub);

endmodule

// File: rtl/circuit1_sched.sv
// rtl/circuit1_sched.sv - scheduled datapath computing z = max(a+b, a+c) and x = a*c - (a+b)
module circuit1_sched
    import circuit1_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [DATAWIDTH-1:0]   a,
    input  logic [DATAWIDTH-1:0]   b,
    input  logic [DATAWIDTH-1:0]   c,
    output logic                   busy,
    output logic                   done,
    output logic [DATAWIDTH-1:0]   z,
    output logic [2*DATAWIDTH-1:0] x
);

    localparam int W2 = 2 * DATAWIDTH;

    logic [2:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, b_q, c_q;
    logic [DATAWIDTH-1:0] d_q, e_q, z_q;
    logic [W2-1:0]        f_q, x_q;

    logic [W2-1:0]        as_a, as_b, as_res;
    logic                 as_sub;

    circuit1_addsub #(.W(W2)) u_addsub (
        .A      (as_a),
        .B      (as_b),
        .sub    (as_sub),
        .result (as_res)
    );

    // Operand steering for the shared unit: one add/sub per state at most.
    always_comb begin
        state_d = state_q;
        as_a    = '0;
        as_b    = '0;
        as_sub  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_S_D;
            ST_S_D: begin
                state_d = ST_S_E;
                as_a    = W2'(a_q);
                as_b    = W2'(b_q);
            end
            ST_S_E: begin
                state_d = ST_S_CM;
                as_a    = W2'(a_q);
                as_b    = W2'(c_q);
            end
            ST_S_CM: state_d = ST_S_X;
            ST_S_X: begin
                state_d = ST_DONE;
                as_a    = f_q;
                as_b    = W2'(d_q);
                as_sub  = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            z_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (start) begin
                    a_q <= a;
                    b_q <= b;
                    c_q <= c;
                end
                ST_S_D: d_q <= as_res[DATAWIDTH-1:0];
                ST_S_E: e_q <= as_res[DATAWIDTH-1:0];
                ST_S_CM: begin
                    // Strict greater-than so a tie selects e.
                    z_q <= (d_q > e_q) ? d_q : e_q;
                    f_q <= W2'(a_q) * W2'(c_q);
                end
                ST_S_X: x_q <= as_res;
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign z    = z_q;
    assign x    = x_q;

endmodule

// File: tb/tb_circuit1_sched.sv
// tb/tb_circuit1_sched.sv - directed scoreboard bench for circuit1_sched
module tb_circuit1_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a, b, c;
    logic        busy, done;
    logic [7:0]  z;
    logic [15:0] x;

    logic [23:0] sb_q[$];
    int          nvec;
    int          nerr;

    circuit1_sched #(.DATAWIDTH(8)) dut (
        .Clk   (clk),
        .Rst   (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .x     (x)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [7:0] mc);
        int md, me, mz, mx;
        md = (int'(ma) + int'(mb)) % 256;
        me = (int'(ma) + int'(mc)) % 256;
        mz = (md > me) ? md : me;
        mx = int'(ma) * int'(mc) - md;
        if (mx < 0) mx = mx + 65536;
        return {mz[7:0], mx[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic, input bit noise);
        int          n;
        bit          seen;
        logic [23:0] exp;
        @(negedge clk);
        a = ia; b = ib; c = ic; start = 1'b1;
        sb_q.push_back(model(ia, ib, ic));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (noise) start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            exp = sb_q.pop_front();
            chk("done_latency", 32'(n), 32'd5);
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("z", 32'(z), 32'(exp[23:16]));
            chk("x", 32'(x), 32'(exp[15:0]));
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("busy_after_done", 32'(busy), 32'd0);
            @(negedge clk);
            chk("no_queued_start", 32'(busy), 32'd0);
            chk("z_hold", 32'(z), 32'(exp[23:16]));
            chk("x_hold", 32'(x), 32'(exp[15:0]));
        end
    endtask

    initial begin
        logic [7:0]  ops[3][3];
        logic [23:0] exp;
        int          n;
        bit          seen;

        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b1;
        start = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(8'd3, 8'd4, 8'd5, 1'b1);
        run_op(8'd200, 8'd100, 8'd10, 1'b0);
        run_op(8'd0, 8'd5, 8'd0, 1'b0);
        run_op(8'd255, 8'd255, 8'd255, 1'b1);

        // start held high: one accept every 6 cycles
        ops[0] = '{8'd3, 8'd4, 8'd5};
        ops[1] = '{8'd17, 8'd99, 8'd42};
        ops[2] = '{8'd250, 8'd9, 8'd128};
        @(negedge clk);
        a = ops[0][0]; b = ops[0][1]; c = ops[0][2]; start = 1'b1;
        sb_q.push_back(model(ops[0][0], ops[0][1], ops[0][2]));
        for (int k = 0; k < 3; k++) begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 12) begin
                @(negedge clk);
                n++;
                if (done) seen = 1'b1;
            end
            chk("b2b_done_seen", 32'(seen), 32'd1);
            if (seen) begin
                exp = sb_q.pop_front();
                chk("b2b_period", 32'(n), (k == 0) ? 32'd5 : 32'd6);
                chk("b2b_z", 32'(z), 32'(exp[23:16]));
                chk("b2b_x", 32'(x), 32'(exp[15:0]));
            end
            if (k < 2) begin
                a = ops[k+1][0]; b = ops[k+1][1]; c = ops[k+1][2];
                sb_q.push_back(model(ops[k+1][0], ops[k+1][1], ops[k+1][2]));
            end else begin
                start = 1'b0;
            end
        end
        sb_q.delete();
        repeat (2) @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        // reset asserted in S_CM aborts the run
        @(negedge clk);
        a = 8'd60; b = 8'd70; c = 8'd80; start = 1'b1;
        sb_q.push_back(model(8'd60, 8'd70, 8'd80));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_z", 32'(z), 32'd0);
        chk("abort_x", 32'(x), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(8'd10, 8'd20, 8'd30, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
